// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter.
// State encodings and master identifiers.
package mem_arb_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_e;

  localparam logic ID_I = 1'b0;
  localparam logic ID_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_outstanding_ctr.sv
// Up/down counter of accepted-but-unreturned reads.
// A decrement with the counter empty is ignored and flagged as underflow.
module outstanding_ctr #(
  parameter int MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty,
  output logic o_underflow
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] r_count;
  logic          w_dec;

  assign o_full      = (r_count == CW'(MAX));
  assign o_empty     = (r_count == '0);
  assign o_underflow = i_dec & o_empty;
  assign w_dec       = i_dec & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && !w_dec) begin
      r_count <= r_count + CW'(1);
    end else if (w_dec && !i_inc) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between icache and dcache memory ports.
// A grant is held until the owner is idle and all its reads returned.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ic_addr,
  input  logic        i_ic_ren,
  input  logic        i_ic_wen,
  input  logic [31:0] i_ic_wdata,
  output logic        o_ic_ready,
  output logic [31:0] o_ic_rdata,
  output logic        o_ic_valid,
  input  logic [31:0] i_dc_addr,
  input  logic        i_dc_ren,
  input  logic        i_dc_wen,
  input  logic [31:0] i_dc_wdata,
  output logic        o_dc_ready,
  output logic [31:0] o_dc_rdata,
  output logic        o_dc_valid,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic        o_protocol_err
);

  state_e r_state;
  logic   r_last;
  logic   r_err;

  logic w_own_i;
  logic w_own_d;
  logic w_ic_req;
  logic w_dc_req;
  logic w_full;
  logic w_empty;
  logic w_underflow;
  logic w_inc;

  assign w_own_i  = (r_state == OWN_I);
  assign w_own_d  = (r_state == OWN_D);
  assign w_ic_req = i_ic_ren | i_ic_wen;
  assign w_dc_req = i_dc_ren | i_dc_wen;

  assign o_mem_addr  = w_own_i ? i_ic_addr :
                       w_own_d ? i_dc_addr : '0;
  assign o_mem_wdata = w_own_i ? i_ic_wdata :
                       w_own_d ? i_dc_wdata : '0;

  // Both read and write are held off while the read window is full.
  assign o_mem_ren = ((w_own_i & i_ic_ren) |
                      (w_own_d & i_dc_ren)) & ~w_full;
  assign o_mem_wen = ((w_own_i & i_ic_wen) |
                      (w_own_d & i_dc_wen)) & ~w_full;

  assign o_ic_ready = w_own_i & i_mem_ready & ~w_full;
  assign o_dc_ready = w_own_d & i_mem_ready & ~w_full;

  assign w_inc = o_mem_ren & i_mem_ready;

  assign o_ic_valid = i_mem_valid & w_own_i & ~w_empty;
  assign o_dc_valid = i_mem_valid & w_own_d & ~w_empty;
  assign o_ic_rdata = w_own_i ? i_mem_rdata : '0;
  assign o_dc_rdata = w_own_d ? i_mem_rdata : '0;

  assign o_protocol_err = r_err;

  outstanding_ctr #(
    .MAX(MAX_OUTSTANDING)
  ) u_ctr (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_inc      (w_inc),
    .i_dec      (i_mem_valid),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_underflow(w_underflow)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_last  <= ID_D;
      r_err   <= 1'b0;
    end else begin
      if (w_underflow) r_err <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_ic_req && (!w_dc_req || r_last == ID_D)) begin
            r_state <= OWN_I;
            r_last  <= ID_I;
          end else if (w_dc_req) begin
            r_state <= OWN_D;
            r_last  <= ID_D;
          end
        end
        OWN_I: begin
          if (!w_ic_req && w_empty) begin
            if (w_dc_req) begin
              r_state <= OWN_D;
              r_last  <= ID_D;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        OWN_D: begin
          if (!w_dc_req && w_empty) begin
            if (w_ic_req) begin
              r_state <= OWN_I;
              r_last  <= ID_I;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model.
// Memory returns addr ^ K for every accepted read, in order.
module tb_mem_arbiter;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ic_addr = '0, dc_addr = '0;
  logic        ic_ren = 0, ic_wen = 0, dc_ren = 0, dc_wen = 0;
  logic [31:0] ic_wdata = '0, dc_wdata = '0;
  logic        ic_ready, ic_valid, dc_ready, dc_valid;
  logic [31:0] ic_rdata, dc_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen, mem_valid, perr;
  logic        mrdy = 1'b1;
  logic        mvalid = 1'b0;
  logic [31:0] mrdata = '0;
  logic        inj = 1'b0;

  int n_err = 0;
  int n_chk = 0;
  int lat = 1;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rd_t;
  rd_t q[$];

  always #5 clk = ~clk;

  assign mem_valid = mvalid | inj;
  assign mem_rdata = mvalid ? mrdata : 32'h0;

  mem_arbiter dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ic_addr     (ic_addr),
    .i_ic_ren      (ic_ren),
    .i_ic_wen      (ic_wen),
    .i_ic_wdata    (ic_wdata),
    .o_ic_ready    (ic_ready),
    .o_ic_rdata    (ic_rdata),
    .o_ic_valid    (ic_valid),
    .i_dc_addr     (dc_addr),
    .i_dc_ren      (dc_ren),
    .i_dc_wen      (dc_wen),
    .i_dc_wdata    (dc_wdata),
    .o_dc_ready    (dc_ready),
    .o_dc_rdata    (dc_rdata),
    .o_dc_valid    (dc_valid),
    .o_mem_addr    (mem_addr),
    .o_mem_ren     (mem_ren),
    .o_mem_wen     (mem_wen),
    .o_mem_wdata   (mem_wdata),
    .i_mem_ready   (mrdy),
    .i_mem_rdata   (mem_rdata),
    .i_mem_valid   (mem_valid),
    .o_protocol_err(perr)
  );

  always @(posedge clk) begin : mem_model
    int nc;
    nc = cyc + 1;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (mvalid && q.size() > 0) void'(q.pop_front());
      if (mem_ren && mrdy) q.push_back('{mem_addr, cyc + lat});
    end
    cyc <= nc;
    if (rst_n && q.size() > 0 && q[0].due == nc) begin
      mvalid <= 1'b1;
      mrdata <= q[0].addr ^ K;
    end else begin
      mvalid <= 1'b0;
      mrdata <= 32'h0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ic_ren = 0; ic_wen = 0; dc_ren = 0; dc_wen = 0;
    ic_addr = '0; dc_addr = '0; ic_wdata = '0; dc_wdata = '0;
    inj = 0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    step();
    do_reset();
    #1;
    chk("rst addr", mem_addr, 32'h0);
    chk("rst ren", mem_ren, 0);
    chk("rst ic_rdy", ic_ready, 0);
    chk("rst dc_rdy", dc_ready, 0);
    chk("rst err", perr, 0);

    // single dcache read burst, latency 1
    lat = 1;
    dc_ren = 1; dc_addr = 32'h100;
    #1;
    chk("t1 idle ren", mem_ren, 0);
    chk("t1 idle rdy", dc_ready, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      dc_addr = 32'h100 + 32'(4 * i);
      #1;
      chk("t1 ren", mem_ren, 1);
      chk("t1 addr", mem_addr, 32'h100 + 32'(4 * i));
      chk("t1 rdy", dc_ready, 1);
      chk("t1 ic_rdy", ic_ready, 0);
      chk("t1 ic_vld", ic_valid, 0);
      if (i > 0) begin
        chk("t1 vld", dc_valid, 1);
        chk("t1 data", dc_rdata, (32'h100 + 32'(4 * (i - 1))) ^ K);
      end else begin
        chk("t1 vld0", dc_valid, 0);
      end
      step();
    end
    dc_ren = 0;
    #1;
    chk("t1 last vld", dc_valid, 1);
    chk("t1 last data", dc_rdata, 32'h10C ^ K);
    chk("t1 held", mem_addr, 32'h10C);
    step();
    chk("t1 rel vld", dc_valid, 0);
    chk("t1 rel held", mem_addr, 32'h10C);
    step();
    chk("t1 idle addr", mem_addr, 32'h0);

    // simultaneous first request after reset
    do_reset();
    ic_ren = 1; ic_addr = 32'h40;
    dc_ren = 1; dc_addr = 32'h80;
    #1;
    chk("t2 idle ren", mem_ren, 0);
    step();
    chk("t2 tie addr", mem_addr, 32'h40);
    chk("t2 ic_rdy", ic_ready, 1);
    chk("t2 dc_rdy", dc_ready, 0);
    step();
    ic_ren = 0;
    #1;
    chk("t2 ic_vld", ic_valid, 1);
    chk("t2 ic_data", ic_rdata, 32'h40 ^ K);
    chk("t2 dc_vld", dc_valid, 0);
    step();
    chk("t2 rel dc_rdy", dc_ready, 0);
    chk("t2 rel ren", mem_ren, 0);
    step();
    chk("t2 handoff addr", mem_addr, 32'h80);
    chk("t2 handoff rdy", dc_ready, 1);
    step();
    dc_ren = 0;
    #1;
    chk("t2 dc_vld", dc_valid, 1);
    chk("t2 dc_data", dc_rdata, 32'h80 ^ K);
    step();
    step();
    ic_ren = 1; dc_ren = 1;
    #1;
    chk("t2 idle2 ren", mem_ren, 0);
    step();
    chk("t2 tie2 addr", mem_addr, 32'h40);
    chk("t2 tie2 rdy", ic_ready, 1);
    ic_ren = 0; dc_ren = 0;
    step();
    step();
    chk("t2 idle3", mem_addr, 32'h0);

    // outstanding limit, latency 10
    do_reset();
    lat = 10;
    dc_ren = 1; dc_addr = 32'h300;
    for (int c = 0; c < 18; c++) begin
      logic er, ev;
      er = (c >= 1 && c <= 4) || (c >= 12 && c <= 15);
      ev = (c >= 11 && c <= 14);
      #1;
      chk($sformatf("t3 rdy c%0d", c), dc_ready, er);
      chk($sformatf("t3 ren c%0d", c), mem_ren, er);
      chk($sformatf("t3 vld c%0d", c), dc_valid, ev);
      step();
    end

    // hold until drained, latency 3
    do_reset();
    lat = 3;
    ic_ren = 1; ic_addr = 32'h400;
    step();
    for (int c = 1; c < 3; c++) begin
      #1;
      chk("t4 ic_rdy", ic_ready, 1);
      step();
    end
    ic_ren = 0;
    dc_wen = 1; dc_addr = 32'h200; dc_wdata = 32'hDEADBEEF;
    for (int c = 3; c < 7; c++) begin
      #1;
      chk($sformatf("t4 wen c%0d", c), mem_wen, 0);
      chk($sformatf("t4 dc_rdy c%0d", c), dc_ready, 0);
      chk($sformatf("t4 ic_vld c%0d", c), ic_valid, (c == 4 || c == 5));
      step();
    end
    chk("t4 wen", mem_wen, 1);
    chk("t4 wdata", mem_wdata, 32'hDEADBEEF);
    chk("t4 waddr", mem_addr, 32'h200);
    chk("t4 dc_rdy", dc_ready, 1);
    step();
    dc_wen = 0;
    #1;
    chk("t4 wen off", mem_wen, 0);
    step();
    chk("t4 idle wdata", mem_wdata, 32'h0);
    chk("t4 idle addr", mem_addr, 32'h0);

    // stray valid, then reset mid-burst
    do_reset();
    lat = 1;
    inj = 1;
    #1;
    chk("t5 stray ic_vld", ic_valid, 0);
    chk("t5 stray dc_vld", dc_valid, 0);
    chk("t5 err pre", perr, 0);
    step();
    inj = 0;
    chk("t5 err set", perr, 1);
    lat = 10;
    dc_ren = 1; dc_addr = 32'h600;
    step();
    chk("t5 err sticky", perr, 1);
    step();
    chk("t5 burst rdy", dc_ready, 1);
    rst_n = 0;
    dc_ren = 0;
    step();
    chk("t5 rst err", perr, 0);
    chk("t5 rst addr", mem_addr, 32'h0);
    chk("t5 rst rdy", dc_ready, 0);
    rst_n = 1;
    lat = 1;
    ic_ren = 1; ic_addr = 32'h500;
    #1;
    chk("t5 new idle", mem_ren, 0);
    step();
    chk("t5 new addr", mem_addr, 32'h500);
    chk("t5 new rdy", ic_ready, 1);
    step();
    ic_ren = 0;
    #1;
    chk("t5 new vld", ic_valid, 1);
    chk("t5 new data", ic_rdata, 32'h500 ^ K);
    step();
    step();
    chk("t5 end idle", mem_addr, 32'h0);
    chk("t5 end err", perr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter between the instruction cache and data cache miss/write-through ports and the single external memory port. Each cache drives its memory-side interface (ready/addr/ren/wen/wdata/rdata/valid) into this block exactly as it would drive memory directly; the arbiter grants one cache at a time and forwards its traffic to memory. A grant is held until the owning cache is idle and all of its reads have returned. Read responses therefore always belong to the current owner.

## Interface
- MAX_OUTSTANDING, 4: maximum accepted-but-unreturned reads; at the limit, ready to the owner is withheld.
- CW, $clog2(MAX_OUTSTANDING+1): outstanding counter width (derived, not overridden).
- i_clk  in  1  clock; single clock domain.
- i_rst_n  in  1  synchronous active-low reset.
- i_ic_addr  in  32  icache request address (word aligned).
- i_ic_ren  in  1  icache read request.
- i_ic_wen  in  1  icache write request (tied 0 in the current core; still arbitrated).
- i_ic_wdata  in  32  icache write data.
- o_ic_ready  out  1  memory accepts the icache request this cycle.
- o_ic_rdata  out  32  read data to icache.
- o_ic_valid  out  1  o_ic_rdata valid.
- i_dc_addr, i_dc_ren, i_dc_wen, i_dc_wdata  in  32/1/1/32  dcache request, same meaning as icache.
- o_dc_ready, o_dc_rdata, o_dc_valid  out  1/32/1  dcache response, same meaning as icache.
- o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata  out  32/1/1/32  forwarded request to memory.
- i_mem_ready, i_mem_rdata, i_mem_valid  in  1/32/1  memory handshake and in-order read response.
- o_protocol_err  out  1  sticky; set by i_mem_valid while the outstanding counter is 0.

## Operation
- States: IDLE, OWN_I, OWN_D. Register last_grant (I/D) drives round-robin tie-breaking.
- A master is "requesting" when its ren|wen is high.
- IDLE: no forwarding. If only one master is requesting, go to that master's OWN state. If both are requesting, grant the master that is not last_grant. last_grant updates on the grant.
- OWN_x: forward x's addr/ren/wen/wdata to memory combinationally.
  - o_x_ready = i_mem_ready & (count < MAX_OUTSTANDING). The other master's ready is 0.
  - o_mem_ren/o_mem_wen are gated to 0 while count == MAX_OUTSTANDING.
- Counter: +1 on an accepted read (o_mem_ren & i_mem_ready). −1 on i_mem_valid. Both events in the same cycle leave it unchanged. Accepted writes are not counted.
- Response routing: o_x_valid = i_mem_valid & state==OWN_x & count!=0. o_x_rdata = i_mem_rdata when state==OWN_x, else 0.
- Stray response: i_mem_valid with count==0 is dropped (no valid is routed) and sets o_protocol_err; the counter stays 0.
- Release from OWN_x requires x to be not requesting and count==0 in the same cycle.
  - Next state is OWN_y if y is requesting (direct handoff, last_grant←y), else IDLE.
  - If x re-requests in the release cycle, the grant is held.
- No output is driven when there is no owner: mem addr/wdata = 0, ren/wen = 0, all ready/valid = 0.

## Timing
- Reset (i_rst_n low at a clock edge): state=IDLE, count=0, last_grant=D (icache wins the first tie), o_protocol_err=0. All outputs reach the no-owner values from the next cycle.
- Reset mid-burst discards the in-flight count. Memory must share the reset, otherwise late responses flag o_protocol_err.
- Grant latency: a request first seen in IDLE in cycle N is forwarded in cycle N+1. On handoff, y is forwarded in the cycle after x releases.
- Forwarding, ready and response paths are combinational in OWN states, adding zero cycles.
- Release is evaluated combinationally in cycle M; the new state takes effect in M+1.
- Starvation bound: a waiting master is granted on the next release of the other master.

## Structure
- Shared defs package mem_arb_defs: state encodings (IDLE=2'd0, OWN_I=2'd1, OWN_D=2'd2) and master IDs (ID_I=0, ID_D=1).
- Sub-module outstanding_ctr (parameter MAX): up/down counter with full/empty flags and an underflow-error output. Everything else (FSM, round-robin, muxing) lives in mem_arbiter.

## Test plan
- **Single read burst:** dcache issues 4 reads at 0x100/0x104/0x108/0x10C with memory always ready and 1-cycle latency.
  - Grant occurs the cycle after the request.
  - o_dc_valid pulses 4× with matching data; o_ic_* stays 0.
  - Return to IDLE one cycle after ren drops with count 0.
- **Simultaneous first request:** both masters request out of reset.
  - icache is granted first.
  - After icache releases, dcache gets a direct handoff with no IDLE cycle.
  - Next tie goes to icache again.
- **Outstanding limit:** memory latency 10 cycles, dcache holds ren.
  - Exactly 4 reads are accepted, then o_dc_ready=0 and o_mem_ren=0.
  - Each returned valid re-enables exactly one acceptance.
- **Hold until drained:** icache drops ren while 2 reads are outstanding and dcache requests write 0xDEADBEEF@0x200.
  - dcache is not forwarded until both icache reads return.
  - Then o_mem_wen=1 with o_mem_wdata=0xDEADBEEF.
- **Stray valid and reset mid-burst:**
  - i_mem_valid while IDLE sets o_protocol_err with no routed valid.
  - Asserting i_rst_n=0 mid-burst clears the error, the count and the grant. The next request is granted normally.
